traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive safety monitor that sits on the `es_light` / `ns_light` outputs of the intersection controller, i.e. the consuming end of that interface. It samples both light codes every cycle, tracks each direction's phase sequence and dwell time, and raises a sticky fault with a coded cause on any unsafe or illegal behaviour. It also counts completed east-south green cycles. It drives nothing back into the controller; its fault output is intended for a top-level safe-state override and for bench checking.

## Interface
- `MIN_GREEN`, default 4: minimum consecutive cycles a direction must hold GREEN before leaving it.
- `MIN_YELLOW`, default 2: minimum consecutive cycles a direction must hold YELLOW before leaving it.
- `MAX_RED`, default 32: maximum consecutive cycles a direction may hold RED.
- `CNT_W`, default 8: width of dwell counters and of the cycle counter; must satisfy 2^CNT_W − 1 ≥ MAX_RED.

Ports:
- `clk` input 1: the single clock, rising-edge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `es_light` input 2: east-south light code.
- `ns_light` input 2: north-south light code.
- `fault_clr` input 1: synchronous request to clear a latched fault.
- `fault` output 1: sticky fault flag.
- `fault_code` output 3: cause of the first fault.
- `fault_dir` output 1: direction of the fault; 0 = es, 1 = ns. Meaningful for codes 3–6 only, otherwise 0.
- `es_cycles` output CNT_W: number of es RED→GREEN transitions; wraps modulo 2^CNT_W.

## Operation
- Light encoding: RED = 2'b00, YELLOW = 2'b01, GREEN = 2'b10, 2'b11 = invalid.
- Legal per-direction transitions are RED→GREEN, GREEN→YELLOW and YELLOW→RED. Holding the same value is also legal.
- Dwell is the number of consecutive samples showing the current value. It is 1 on the first sample of a new value and saturates at 2^CNT_W − 1.
- States:
  - INIT: one cycle. Captures both inputs as previous values and sets both dwells to 1. No transition, dwell or starve checks. Invalid-code and conflict checks are active. Goes to RUN.
  - RUN: all checks every cycle. Any fault goes to FAULT.
  - FAULT: outputs held. Dwell counters, previous values and `es_cycles` frozen. `fault_clr` = 1 goes to INIT.
- Fault codes, listed highest priority first. The first-detected cause is the one latched; at equal priority es wins over ns.
  1. INVALID: either input is 2'b11.
  2. CONFLICT: both inputs are non-RED in the same sample.
  3. ILLEGAL_TRANSITION: a change that is not one of the legal transitions.
  4. SHORT_GREEN: leaving GREEN with the old dwell < MIN_GREEN.
  5. SHORT_YELLOW: leaving YELLOW with the old dwell < MIN_YELLOW.
  6. STARVE: RED dwell reaches MAX_RED + 1.
- `fault_code` = 0 means no fault.
- `es_cycles` increments on a legal es RED→GREEN transition seen in RUN. It does not increment on the sample that faults.

## Timing
- Reset values: `fault` = 0, `fault_code` = 0, `fault_dir` = 0, `es_cycles` = 0. State = INIT. Dwells = 0.
- Reset is asynchronous. Assertion mid-operation clears everything immediately, including a latched fault.
- Latency: for an offending value sampled at posedge N, `fault`, `fault_code` and `fault_dir` are valid immediately after posedge N. All outputs are registered.
- `fault_clr` is sampled at posedge M while in FAULT:
  - After posedge M: outputs are cleared and state is INIT.
  - At posedge M+1: INIT captures the inputs.
  - From posedge M+2: RUN checks apply.
- `fault_clr` outside FAULT is ignored.
- If an offending sample arrives in the same cycle that `fault_clr` is accepted, it is not checked. It is absorbed by INIT on the next cycle, apart from codes 1 and 2, which are still checked there.
- Dwell saturation never wraps. STARVE fires exactly on the sample where RED dwell = MAX_RED + 1.

## Structure
- Package `traffic_pkg` holds:
  - the `light_t` enum (RED, YELLOW, GREEN, INVALID);
  - the `fault_code_t` enum with the codes above;
  - the `mon_state_t` enum (INIT, RUN, FAULT).
- Sub-module `light_phase_tracker`, instantiated once per direction:
  - holds the previous value and the dwell counter;
  - outputs flags for illegal transition, short green, short yellow, starve and red-to-green.
- The top level does:
  - the cross-direction checks (invalid code, conflict);
  - priority selection;
  - the FSM;
  - fault latching and the `es_cycles` counter.

## Test plan
- **Nominal sequence.** Reset low for 2 cycles, then release. es runs GREEN ×4, YELLOW ×2, RED ×10 while ns runs RED ×6, GREEN ×4, YELLOW ×2, RED ×4, repeated 3 times. Required: `fault` = 0 throughout and `es_cycles` = 3.
- **Conflict.** es = GREEN and ns = GREEN in the same cycle. Required: `fault` = 1, `fault_code` = 2, `fault_dir` = 0 after that edge.
- **Short green.** es GREEN for 3 cycles, then YELLOW. Required: `fault_code` = 4, `fault_dir` = 0. Then assert `fault_clr` for 1 cycle; required: `fault` = 0, and two cycles later normal checking resumes.
- **Illegal transition.** ns RED→YELLOW. Required: `fault_code` = 3, `fault_dir` = 1. The same sample also carrying es = 2'b11 must give `fault_code` = 1.
- **Starve.** es held RED and ns cycling legally for 33 cycles. Required: `fault_code` = 6 exactly on es RED dwell 33, and `es_cycles` frozen thereafter.
- **Reset mid-fault.** With the fault latched, pulse `rst` low asynchronously between edges. Required: all outputs 0 immediately, and INIT on the first edge after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic light safety monitor: light codes, fault causes,
// monitor FSM states and the per-direction phase flag bundle.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED     = 2'b00,
    YELLOW  = 2'b01,
    GREEN   = 2'b10,
    INVALID = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_INVALID      = 3'd1,
    FC_CONFLICT     = 3'd2,
    FC_ILLEGAL      = 3'd3,
    FC_SHORT_GREEN  = 3'd4,
    FC_SHORT_YELLOW = 3'd5,
    FC_STARVE       = 3'd6
  } fault_code_t;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic illegal;
    logic short_green;
    logic short_yellow;
    logic starve;
    logic red_to_green;
  } phase_flags_t;

  // Observation bundle: FSM state plus the raw flags from both trackers.
  typedef struct packed {
    mon_state_t   state;
    phase_flags_t es;
    phase_flags_t ns;
  } mon_dbg_t;

  // Only RED->GREEN, GREEN->YELLOW and YELLOW->RED are legal changes.
  function automatic logic is_legal_step(light_t from, light_t to);
    return ((from == RED)    && (to == GREEN))  ||
           ((from == GREEN)  && (to == YELLOW)) ||
           ((from == YELLOW) && (to == RED));
  endfunction

endpackage

// File: rtl/light_phase_tracker.sv
// Per-direction phase tracker: remembers the previous light value and its dwell,
// and flags bad transitions, short phases and red starvation on the current sample.
module light_phase_tracker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 32,
  parameter int CNT_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  light_t       light,
  input  logic         capture,
  input  logic         advance,
  output phase_flags_t flags
);

  localparam logic [CNT_W-1:0] MIN_G = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_RED);

  light_t           prev;
  logic [CNT_W-1:0] dwell;
  logic             changed;

  assign changed = (light != prev);

  // dwell holds the count up to the previous sample, so a held RED reaches
  // MAX_RED + 1 on the current sample exactly when dwell has reached MAX_RED.
  always_comb begin
    flags              = '0;
    flags.illegal      = changed && !is_legal_step(prev, light);
    flags.short_green  = changed && (prev == GREEN)  && (dwell < MIN_G);
    flags.short_yellow = changed && (prev == YELLOW) && (dwell < MIN_Y);
    flags.starve       = !changed && (light == RED) && (dwell >= MAX_R);
    flags.red_to_green = (prev == RED) && (light == GREEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= RED;
      dwell <= '0;
    end else if (capture) begin
      prev  <= light;
      dwell <= CNT_W'(1);
    end else if (advance) begin
      if (changed) begin
        prev  <= light;
        dwell <= CNT_W'(1);
      end else if (dwell != '1) begin
        dwell <= dwell + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor on the intersection light outputs: latches the first
// unsafe condition with its cause and direction, and counts es green cycles.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MAX_RED    = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       es_light,
  input  logic [1:0]       ns_light,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_dir,
  output logic [CNT_W-1:0] es_cycles,
  output mon_dbg_t         dbg
);

  mon_state_t   state;
  light_t       es_l;
  light_t       ns_l;
  phase_flags_t es_f;
  phase_flags_t ns_f;
  fault_code_t  det_code;
  logic         det_dir;
  logic         hit;
  logic         capture;
  logic         advance;

  assign es_l = light_t'(es_light);
  assign ns_l = light_t'(ns_light);

  // Trackers freeze on a faulting sample and throughout FAULT.
  assign capture = (state == INIT);
  assign advance = (state == RUN) && !hit;

  light_phase_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_RED   (MAX_RED),
    .CNT_W     (CNT_W)
  ) u_es (
    .clk    (clk),
    .rst    (rst),
    .light  (es_l),
    .capture(capture),
    .advance(advance),
    .flags  (es_f)
  );

  light_phase_tracker #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_RED   (MAX_RED),
    .CNT_W     (CNT_W)
  ) u_ns (
    .clk    (clk),
    .rst    (rst),
    .light  (ns_l),
    .capture(capture),
    .advance(advance),
    .flags  (ns_f)
  );

  // Priority by cause first; within one cause es is checked before ns.
  always_comb begin
    det_code = FC_NONE;
    det_dir  = 1'b0;
    if ((es_l == INVALID) || (ns_l == INVALID)) begin
      det_code = FC_INVALID;
    end else if ((es_l != RED) && (ns_l != RED)) begin
      det_code = FC_CONFLICT;
    end else if (state == RUN) begin
      if (es_f.illegal) begin
        det_code = FC_ILLEGAL;
      end else if (ns_f.illegal) begin
        det_code = FC_ILLEGAL;
        det_dir  = 1'b1;
      end else if (es_f.short_green) begin
        det_code = FC_SHORT_GREEN;
      end else if (ns_f.short_green) begin
        det_code = FC_SHORT_GREEN;
        det_dir  = 1'b1;
      end else if (es_f.short_yellow) begin
        det_code = FC_SHORT_YELLOW;
      end else if (ns_f.short_yellow) begin
        det_code = FC_SHORT_YELLOW;
        det_dir  = 1'b1;
      end else if (es_f.starve) begin
        det_code = FC_STARVE;
      end else if (ns_f.starve) begin
        det_code = FC_STARVE;
        det_dir  = 1'b1;
      end
    end
  end

  assign hit = (det_code != FC_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
      fault_dir  <= 1'b0;
      es_cycles  <= '0;
    end else begin
      case (state)
        INIT: begin
          if (hit) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_dir  <= det_dir;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (hit) begin
            state      <= FAULT;
            fault      <= 1'b1;
            fault_code <= det_code;
            fault_dir  <= det_dir;
          end else if (es_f.red_to_green) begin
            es_cycles <= es_cycles + CNT_W'(1);
          end
        end
        FAULT: begin
          // The sample accepted with fault_clr is dropped; INIT recaptures next.
          if (fault_clr) begin
            state      <= INIT;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_dir  <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign dbg = {state, es_f, ns_f};

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: scripted scenarios plus random traffic, with a
// reference model pushing expected outputs into a queue checked after each edge.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int MIN_GREEN  = 4;
  localparam int MIN_YELLOW = 2;
  localparam int MAX_RED    = 32;
  localparam int CNT_W      = 8;

  localparam logic [1:0] LR = 2'b00;
  localparam logic [1:0] LY = 2'b01;
  localparam logic [1:0] LG = 2'b10;
  localparam logic [1:0] LX = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       es_light;
  logic [1:0]       ns_light;
  logic             fault_clr;
  logic             fault;
  logic [2:0]       fault_code;
  logic             fault_dir;
  logic [CNT_W-1:0] es_cycles;
  mon_dbg_t         dbg;

  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];

  // Reference model state
  int         m_st;
  logic [1:0] m_prev_es, m_prev_ns;
  int         m_dw_es, m_dw_ns;
  logic       m_fault;
  logic [2:0] m_code;
  logic       m_dir;
  logic [7:0] m_cyc;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_GREEN),
    .MIN_YELLOW(MIN_YELLOW),
    .MAX_RED   (MAX_RED),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .es_light  (es_light),
    .ns_light  (ns_light),
    .fault_clr (fault_clr),
    .fault     (fault),
    .fault_code(fault_code),
    .fault_dir (fault_dir),
    .es_cycles (es_cycles),
    .dbg       (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0;
    m_prev_es = LR;
    m_prev_ns = LR;
    m_dw_es = 0;
    m_dw_ns = 0;
    m_fault = 1'b0;
    m_code = 3'd0;
    m_dir = 1'b0;
    m_cyc = 8'd0;
  endtask

  // Worst per-direction cause (3..6) for one sample, 0 if clean.
  function automatic logic [2:0] dir_code(input logic [1:0] prev, input int dw, input logic [1:0] cur);
    logic legal;
    if (cur != prev) begin
      legal = (prev == LR && cur == LG) || (prev == LG && cur == LY) || (prev == LY && cur == LR);
      if (!legal) return 3'd3;
      if (prev == LG && dw < MIN_GREEN) return 3'd4;
      if (prev == LY && dw < MIN_YELLOW) return 3'd5;
      return 3'd0;
    end
    if (cur == LR && dw + 1 > MAX_RED) return 3'd6;
    return 3'd0;
  endfunction

  task automatic model_step(input logic [1:0] e, input logic [1:0] n, input logic c);
    logic [2:0] code, ce, cn;
    logic dir;
    if (m_st == 2) begin
      if (c) begin
        m_fault = 1'b0;
        m_code = 3'd0;
        m_dir = 1'b0;
        m_st = 0;
      end
      return;
    end
    code = 3'd0;
    dir = 1'b0;
    if (e == LX || n == LX) code = 3'd1;
    else if (e != LR && n != LR) code = 3'd2;
    else if (m_st == 1) begin
      ce = dir_code(m_prev_es, m_dw_es, e);
      cn = dir_code(m_prev_ns, m_dw_ns, n);
      if (ce != 0 && (cn == 0 || ce <= cn)) code = ce;
      else if (cn != 0) begin
        code = cn;
        dir = 1'b1;
      end
    end
    if (code != 0) begin
      m_fault = 1'b1;
      m_code = code;
      m_dir = dir;
      m_st = 2;
      return;
    end
    if (m_st == 0) begin
      m_prev_es = e;
      m_prev_ns = n;
      m_dw_es = 1;
      m_dw_ns = 1;
      m_st = 1;
      return;
    end
    if (m_prev_es == LR && e == LG) m_cyc = m_cyc + 8'd1;
    m_dw_es = (e == m_prev_es) ? ((m_dw_es < 255) ? m_dw_es + 1 : 255) : 1;
    m_dw_ns = (n == m_prev_ns) ? ((m_dw_ns < 255) ? m_dw_ns + 1 : 255) : 1;
    m_prev_es = e;
    m_prev_ns = n;
  endtask

  // driver: one sample per cycle, expected pushed at drive time, popped after the edge
  task automatic drive(input logic [1:0] e, input logic [1:0] n, input logic c);
    logic [12:0] exp_v;
    @(negedge clk);
    es_light = e;
    ns_light = n;
    fault_clr = c;
    model_step(e, n, c);
    exp_q.push_back({m_fault, m_code, m_dir, m_cyc});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    check_val("out", 32'({fault, fault_code, fault_dir, es_cycles}), 32'(exp_v));
  endtask

  initial begin
    logic [1:0] e, n;
    int fault_at;

    es_light = LR;
    ns_light = LR;
    fault_clr = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_fault", 32'(fault), 32'd0);
    check_val("rst_code", 32'(fault_code), 32'd0);
    check_val("rst_dir", 32'(fault_dir), 32'd0);
    check_val("rst_cycles", 32'(es_cycles), 32'd0);
    check_val("rst_state", 32'(dbg.state), 32'(INIT));
    rst = 1'b1;

    // nominal: all-red preamble then three full intersection cycles
    drive(LR, LR, 1'b0);
    drive(LR, LR, 1'b0);
    for (int rep = 0; rep < 3; rep++) begin
      for (int t = 0; t < 16; t++) begin
        e = (t < 4) ? LG : (t < 6) ? LY : LR;
        n = (t < 6) ? LR : (t < 10) ? LG : (t < 12) ? LY : LR;
        drive(e, n, 1'b0);
      end
    end
    check_val("nom_fault", 32'(fault), 32'd0);
    check_val("nom_cycles", 32'(es_cycles), 32'd3);

    // conflict
    drive(LG, LG, 1'b0);
    check_val("cf_fault", 32'(fault), 32'd1);
    check_val("cf_code", 32'(fault_code), 32'd2);
    check_val("cf_dir", 32'(fault_dir), 32'd0);
    drive(LR, LR, 1'b1);
    check_val("clr_fault", 32'(fault), 32'd0);
    check_val("clr_state", 32'(dbg.state), 32'(INIT));
    drive(LR, LR, 1'b0);
    check_val("clr_init", 32'(dbg.state), 32'(RUN));

    // short green, then clear with an unchecked offending sample
    repeat (3) drive(LG, LR, 1'b0);
    drive(LY, LR, 1'b0);
    check_val("sg_code", 32'(fault_code), 32'd4);
    check_val("sg_dir", 32'(fault_dir), 32'd0);
    drive(LY, LR, 1'b1);
    check_val("sg_clr", 32'(fault), 32'd0);
    drive(LY, LR, 1'b0);
    drive(LY, LR, 1'b0);
    drive(LR, LR, 1'b0);
    check_val("resume_ok", 32'(fault), 32'd0);

    // illegal transition on ns, then invalid overriding it
    drive(LR, LY, 1'b0);
    check_val("il_code", 32'(fault_code), 32'd3);
    check_val("il_dir", 32'(fault_dir), 32'd1);
    drive(LR, LR, 1'b1);
    drive(LR, LR, 1'b0);
    drive(LX, LY, 1'b0);
    check_val("inv_code", 32'(fault_code), 32'd1);
    check_val("inv_dir", 32'(fault_dir), 32'd0);

    // starve: es held red, ns cycling legally
    drive(LR, LR, 1'b1);
    drive(LR, LR, 1'b0);
    fault_at = -1;
    for (int k = 1; k <= 40; k++) begin
      n = (((k - 1) % 10) < 4) ? LG : (((k - 1) % 10) < 6) ? LY : LR;
      drive(LR, n, 1'b0);
      if (fault && fault_at < 0) fault_at = k;
    end
    check_val("starve_at", 32'(fault_at), 32'd32);
    check_val("starve_code", 32'(fault_code), 32'd6);
    check_val("starve_dir", 32'(fault_dir), 32'd0);
    drive(LG, LR, 1'b0);
    drive(LG, LR, 1'b0);
    check_val("cyc_frozen", 32'(es_cycles), 32'd4);

    // asynchronous reset between edges while the fault is latched
    #2;
    rst = 1'b0;
    #1;
    check_val("ar_fault", 32'(fault), 32'd0);
    check_val("ar_code", 32'(fault_code), 32'd0);
    check_val("ar_dir", 32'(fault_dir), 32'd0);
    check_val("ar_cycles", 32'(es_cycles), 32'd0);
    check_val("ar_state", 32'(dbg.state), 32'(INIT));
    rst = 1'b1;
    model_reset();
    drive(LR, LR, 1'b0);
    check_val("init_after_rst", 32'(dbg.state), 32'(RUN));

    // random traffic with random clears
    repeat (150) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
